// File: rtl/lz77_pkg.sv
// lz77_pkg: shared types and default geometry for the LZ77 codec.
//   state_t  - controller states (exposed as the `state` signal in lz77_codec)
//   token_t  - {offset, len, ch, last} token at the default geometry
//   DEF_*    - default character width, search/look-ahead depths, field widths
package lz77_pkg;

    localparam int DEF_CHAR_W   = 8;
    localparam int DEF_SB_DEPTH = 9;
    localparam int DEF_LA_DEPTH = 8;
    localparam int DEF_OFF_W    = $clog2(DEF_SB_DEPTH);
    localparam int DEF_LEN_W    = $clog2(DEF_LA_DEPTH);

    // D_WAIT is the inter-token wait of a decode string: it accepts like IDLE
    // but never resamples mode.
    typedef enum logic [2:0] {
        IDLE, E_FILL, E_SEARCH, E_EMIT, E_SHIFT, D_COPY, D_LIT, D_WAIT
    } state_t;

    typedef struct packed {
        logic [DEF_OFF_W-1:0]  offset;
        logic [DEF_LEN_W-1:0]  len;
        logic [DEF_CHAR_W-1:0] ch;
        logic                  last;
    } token_t;

endpackage

// File: rtl/lz77_match_len.sv
// lz77_match_len: combinational match length for one candidate offset.
//   hist   - search buffer, hist[0] is the most recent character
//   la     - look-ahead buffer, la[0] is the oldest pending character
//   la_cnt - number of valid look-ahead characters
//   offset - candidate offset (caller guarantees offset < SB_DEPTH)
//   len    - consecutive matches from la[0], capped at la_cnt-1
module lz77_match_len #(
    parameter int CHAR_W   = 8,
    parameter int SB_DEPTH = 9,
    parameter int LA_DEPTH = 8,
    parameter int OFF_W    = $clog2(SB_DEPTH),
    parameter int LEN_W    = $clog2(LA_DEPTH),
    parameter int LC_W     = $clog2(LA_DEPTH + 1)
) (
    input  logic [CHAR_W-1:0] hist [SB_DEPTH],
    input  logic [CHAR_W-1:0] la   [LA_DEPTH],
    input  logic [LC_W-1:0]   la_cnt,
    input  logic [OFF_W-1:0]  offset,
    output logic [LEN_W-1:0]  len
);

    localparam int LA_IW = $clog2(LA_DEPTH);

    int                cap;
    int                n;
    logic              run;
    logic [CHAR_W-1:0] ref_c;

    // Past the start of the window the match runs into the look-ahead itself,
    // which is what lets a single token describe a repeating run.
    always_comb begin
        cap   = int'(la_cnt) - 1;
        n     = 0;
        run   = 1'b1;
        ref_c = '0;
        for (int i = 0; i < LA_DEPTH; i++) begin
            if (i <= int'(offset)) ref_c = hist[OFF_W'(int'(offset) - i)];
            else                   ref_c = la[LA_IW'(i - int'(offset) - 1)];
            if (run && n < cap && la[i] == ref_c) n = n + 1;
            else                                  run = 1'b0;
        end
        len = LEN_W'(n);
    end

endmodule

// File: rtl/lz77_codec.sv
// lz77_codec: parametrised LZ77 encoder/decoder with ready/valid on both sides.
//   clk, reset        - clock, synchronous active-high reset
//   mode              - 0 encode / 1 decode, taken from the first beat of a string
//   in_valid/in_ready - input handshake; in_char/in_offset/in_len/in_last payload
//   out_valid/out_ready - output handshake; out_offset/out_len/out_char/out_last
//   err               - sticky decode error
// Handshake: a beat moves on a cycle where valid && ready are both high; while
// out_valid is high and out_ready low, every out_* holds its value.
// Build option: define LZ77_DECODE_CHECK_EN to flag decode tokens that reach
// beyond the history (err set, copied chars forced to 0); otherwise err is 0.
module lz77_codec
    import lz77_pkg::*;
#(
    parameter int CHAR_W   = DEF_CHAR_W,
    parameter int SB_DEPTH = DEF_SB_DEPTH,
    parameter int LA_DEPTH = DEF_LA_DEPTH,
    parameter int OFF_W    = $clog2(SB_DEPTH),
    parameter int LEN_W    = $clog2(LA_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    input  logic [OFF_W-1:0]  in_offset,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OFF_W-1:0]  out_offset,
    output logic [LEN_W-1:0]  out_len,
    output logic [CHAR_W-1:0] out_char,
    output logic              out_last,
    output logic              err
);

    localparam int HC_W  = $clog2(SB_DEPTH + 1);
    localparam int LC_W  = $clog2(LA_DEPTH + 1);
    localparam int LA_IW = $clog2(LA_DEPTH);

    typedef struct packed {
        logic [OFF_W-1:0]  offset;
        logic [LEN_W-1:0]  len;
        logic [CHAR_W-1:0] ch;
        logic              last;
    } tok_t;

    state_t            state, state_nx;
    logic [CHAR_W-1:0] hist [SB_DEPTH];
    logic [HC_W-1:0]   hist_cnt;
    logic [CHAR_W-1:0] la   [LA_DEPTH];
    logic [LC_W-1:0]   la_cnt;
    logic              last_seen;
    logic [OFF_W-1:0]  srch_off, best_off;
    logic [LEN_W-1:0]  best_len, cand_len, rem;
    logic [LEN_W:0]    shift_cnt;
    tok_t              tok;
    logic              tok_bad, bad_in, err_q;
    logic              ready_raw, in_fire, out_fire, dec_take;
    logic              push_hist, clear_hist;
    logic [CHAR_W-1:0] push_char, copy_char;

    lz77_match_len #(
        .CHAR_W(CHAR_W), .SB_DEPTH(SB_DEPTH), .LA_DEPTH(LA_DEPTH),
        .OFF_W(OFF_W), .LEN_W(LEN_W), .LC_W(LC_W)
    ) u_match (
        .hist(hist), .la(la), .la_cnt(la_cnt), .offset(srch_off), .len(cand_len)
    );

    assign in_ready = ready_raw && !reset;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign dec_take = in_fire && (state == D_WAIT || (state == IDLE && mode));
    assign err      = err_q;

`ifdef LZ77_DECODE_CHECK_EN
    assign bad_in = (in_len != '0) && (HC_W'(in_offset) >= hist_cnt);
`else
    assign bad_in = 1'b0;
`endif

    // Offsets past the array read as 0; a flagged token always copies 0.
    always_comb begin
        copy_char = '0;
        if (int'(tok.offset) < SB_DEPTH && !tok_bad) copy_char = hist[tok.offset];
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        ready_raw  = 1'b0;
        out_valid  = 1'b0;
        out_offset = '0;
        out_len    = '0;
        out_char   = '0;
        out_last   = 1'b0;
        case (state)
            IDLE, D_WAIT: begin
                ready_raw = 1'b1;
                if (in_valid) begin
                    if (state == IDLE && !mode) state_nx = E_FILL;
                    else                        state_nx = (in_len == '0) ? D_LIT : D_COPY;
                end
            end
            E_FILL: begin
                if (last_seen || la_cnt == LC_W'(LA_DEPTH)) state_nx = E_SEARCH;
                else                                         ready_raw = 1'b1;
            end
            E_SEARCH: if (srch_off == OFF_W'(SB_DEPTH - 1)) state_nx = E_EMIT;
            E_EMIT: begin
                out_valid  = 1'b1;
                out_offset = best_off;
                out_len    = best_len;
                out_char   = la[best_len];
                out_last   = last_seen && ((LC_W'(best_len) + LC_W'(1)) == la_cnt);
                if (out_ready) state_nx = E_SHIFT;
            end
            E_SHIFT: begin
                if (shift_cnt == (LEN_W+1)'(1)) begin
                    if (last_seen && la_cnt == LC_W'(1)) state_nx = IDLE;
                    else if (last_seen)                  state_nx = E_SEARCH;
                    else                                 state_nx = E_FILL;
                end
            end
            D_COPY: begin
                out_valid = 1'b1;
                out_char  = copy_char;
                if (out_ready && rem == LEN_W'(1)) state_nx = D_LIT;
            end
            D_LIT: begin
                out_valid = 1'b1;
                out_char  = tok.ch;
                out_last  = tok.last;
                if (out_ready) state_nx = tok.last ? IDLE : D_WAIT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        push_hist  = 1'b0;
        push_char  = '0;
        clear_hist = 1'b0;
        case (state)
            E_SHIFT: begin
                push_hist  = 1'b1;
                push_char  = la[0];
                clear_hist = (state_nx == IDLE);
            end
            D_COPY: begin
                push_hist = out_fire;
                push_char = copy_char;
            end
            D_LIT: begin
                push_hist  = out_fire;
                push_char  = tok.ch;
                clear_hist = out_fire && tok.last;
            end
            default: ;
        endcase
    end

    // History: shift register, newest at index 0, count saturates at depth.
    always_ff @(posedge clk) begin
        if (reset || clear_hist) begin
            for (int k = 0; k < SB_DEPTH; k++) hist[k] <= '0;
            hist_cnt <= '0;
        end else if (push_hist) begin
            for (int k = SB_DEPTH - 1; k > 0; k--) hist[k] <= hist[k-1];
            hist[0] <= push_char;
            if (hist_cnt != HC_W'(SB_DEPTH)) hist_cnt <= hist_cnt + 1'b1;
        end
    end

    // Look-ahead fill/drain and the per-token search bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LA_DEPTH; k++) la[k] <= '0;
            la_cnt    <= '0;
            last_seen <= 1'b0;
            srch_off  <= '0;
            best_off  <= '0;
            best_len  <= '0;
            shift_cnt <= '0;
        end else begin
            if (in_fire && (state == E_FILL || (state == IDLE && !mode))) begin
                la[LA_IW'(la_cnt)] <= in_char;
                la_cnt             <= la_cnt + 1'b1;
                last_seen          <= in_last;
            end
            if (state != E_SEARCH && state_nx == E_SEARCH) begin
                srch_off <= '0;
                best_off <= '0;
                best_len <= '0;
            end else if (state == E_SEARCH) begin
                srch_off <= srch_off + 1'b1;
                // Strict '>' keeps the smallest offset among equal lengths.
                if (HC_W'(srch_off) < hist_cnt && cand_len > best_len) begin
                    best_off <= srch_off;
                    best_len <= cand_len;
                end
            end
            if (state == E_EMIT && out_fire) shift_cnt <= {1'b0, best_len} + 1'b1;
            if (state == E_SHIFT) begin
                for (int k = 0; k < LA_DEPTH - 1; k++) la[k] <= la[k+1];
                la[LA_DEPTH-1] <= '0;
                la_cnt         <= la_cnt - 1'b1;
                shift_cnt      <= shift_cnt - 1'b1;
                if (clear_hist) last_seen <= 1'b0;
            end
        end
    end

    // Decode token register and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            tok     <= '0;
            rem     <= '0;
            tok_bad <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (dec_take) begin
                tok     <= '{offset: in_offset, len: in_len, ch: in_char, last: in_last};
                rem     <= in_len;
                tok_bad <= bad_in;
                if (bad_in) err_q <= 1'b1;
            end else if (state == D_COPY && out_fire) begin
                rem <= rem - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lz77_codec.sv
// tb_lz77_codec: directed scoreboard bench for lz77_codec (default geometry).
// Stimulus pushes hand-computed output beats into exp_q; the monitor pops and
// compares on every accepted output beat.
module tb_lz77_codec;
    import lz77_pkg::*;

    localparam int CW = DEF_CHAR_W;
    localparam int OW = DEF_OFF_W;
    localparam int LW = DEF_LEN_W;
    localparam int TW = $bits(token_t);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_char = '0;
    logic [OW-1:0] in_offset = '0;
    logic [LW-1:0] in_len = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_offset;
    logic [LW-1:0] out_len;
    logic [CW-1:0] out_char;
    logic          out_last;
    logic          err;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] exp_beat;
    int            xfer_cyc[$];
    int            start_cyc[$];
    logic          pend = 1'b0;

    lz77_codec dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .in_offset(in_offset), .in_len(in_len), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_offset(out_offset),
        .out_len(out_len), .out_char(out_char), .out_last(out_last), .err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: run still active at %0t, required finish", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] tk(input int off, input int len,
                                         input logic [CW-1:0] c, input logic last);
        token_t t;
        t.offset = OW'(off);
        t.len    = LW'(len);
        t.ch     = c;
        t.last   = last;
        return t;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+#1; returns at posedge+#1 after the beat transferred.
    task automatic send(input logic m, input int off, input int len,
                        input logic [CW-1:0] ch, input logic last);
        int t;
        mode = m; in_offset = OW'(off); in_len = LW'(len);
        in_char = ch; in_last = last; in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 300);
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", t);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic enc(input string s);
        for (int i = 0; i < s.len(); i++) send(1'b0, 0, 0, s[i], (i == s.len() - 1));
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk({"drain_", name}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            pend = 1'b0;
        end else if (out_valid) begin
            if (!pend) begin
                start_cyc.push_back(cyc);
                pend = 1'b1;
            end
            if (out_ready) begin
                xfer_cyc.push_back(cyc);
                pend = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got %0h expected none",
                             {out_offset, out_len, out_char, out_last});
                end else begin
                    exp_beat = exp_q.pop_front();
                    chk("out_beat", {out_offset, out_len, out_char, out_last}, exp_beat);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 0);
        chk("rst_out_char",  out_char, 0);
        chk("rst_err",       err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready",  in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        @(posedge clk); #1;

        // Encode "aaaa": literal then an overlapped run of 2.
        exp_q.push_back(tk(0, 0, "a", 0));
        exp_q.push_back(tk(0, 2, "a", 1));
        xfer_cyc.delete();
        start_cyc.delete();
        enc("aaaa");
        drain("enc_aaaa");
        // Shift (1) + 9 search cycles + 1 to reach the emit state.
        if (start_cyc.size() >= 2 && xfer_cyc.size() >= 1)
            chk("search_gap", start_cyc[1] - xfer_cyc[0], 11);
        else begin
            checks++; errors++;
            $display("FAIL search_gap: got %0d beats expected 2", start_cyc.size());
        end

        // Encode "abcabcd".
        exp_q.push_back(tk(0, 0, "a", 0));
        exp_q.push_back(tk(0, 0, "b", 0));
        exp_q.push_back(tk(0, 0, "c", 0));
        exp_q.push_back(tk(2, 3, "d", 1));
        enc("abcabcd");
        drain("enc_abcabcd");

        // Decode the same tokens, stalling the sink during the first copy.
        exp_q.push_back(tk(0, 0, "a", 0));
        exp_q.push_back(tk(0, 0, "b", 0));
        exp_q.push_back(tk(0, 0, "c", 0));
        exp_q.push_back(tk(0, 0, "a", 0));
        exp_q.push_back(tk(0, 0, "b", 0));
        exp_q.push_back(tk(0, 0, "c", 0));
        exp_q.push_back(tk(0, 0, "d", 1));
        send(1'b1, 0, 0, "a", 0);
        send(1'b1, 0, 0, "b", 0);
        send(1'b1, 0, 0, "c", 0);
        send(1'b1, 2, 3, "d", 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid",    out_valid, 1);
            chk("stall_char",     out_char, "a");
            chk("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("dec_abcd");

        // Decode "aaaa" tokens: copy with length > offset+1.
        exp_q.push_back(tk(0, 0, "a", 0));
        exp_q.push_back(tk(0, 0, "a", 0));
        exp_q.push_back(tk(0, 0, "a", 0));
        exp_q.push_back(tk(0, 0, "a", 1));
        send(1'b1, 0, 0, "a", 0);
        send(1'b1, 0, 2, "a", 1);
        drain("dec_aaaa");

        // Reset during the first E_SHIFT of "abcabcd".
        exp_q.push_back(tk(0, 0, "a", 0));
        enc("abcabcd");
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(out_valid && out_ready) && t < 100);
        chk("first_tok_seen", out_valid && out_ready, 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_out_valid",  out_valid, 0);
        chk("mid_rst_out_offset", out_offset, 0);
        chk("mid_rst_out_len",    out_len, 0);
        chk("mid_rst_out_char",   out_char, 0);
        chk("mid_rst_out_last",   out_last, 0);
        chk("mid_rst_in_ready",   in_ready, 0);
        chk("mid_rst_err",        err, 0);
        chk("mid_rst_queue",      exp_q.size(), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(tk(0, 0, "a", 0));
        exp_q.push_back(tk(0, 0, "b", 1));
        enc("ab");
        drain("enc_ab");

        // Out-of-range decode token after two history chars.
        exp_q.push_back(tk(0, 0, "p", 0));
        exp_q.push_back(tk(0, 0, "q", 0));
        exp_q.push_back(tk(0, 0, 8'h00, 0));
        exp_q.push_back(tk(0, 0, 8'h00, 0));
        exp_q.push_back(tk(0, 0, "x", 1));
        send(1'b1, 0, 0, "p", 0);
        send(1'b1, 0, 0, "q", 0);
        send(1'b1, 5, 2, "x", 1);
        drain("dec_bad");
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef LZ77_DECODE_CHECK_EN
        chk("err_sticky", err, 1);
`else
        chk("err_tied", err, 0);
`endif

        chk("final_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
